// File: rtl/pmem_line_arbiter.sv
// Arbitrates I-cache and D-cache line misses onto one 4-beat x 64-bit burst memory port.
// Optional PMEM_ARB_RR_EN: round-robin between the caches on a clash (default: D-over-I priority).
module pmem_line_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned BEAT_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_addr,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_addr,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BEAT_W-1:0] mem_wdata,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam int unsigned BEATS = LINE_W / BEAT_W;
    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        RESP
    } state_e;

    state_e              state_q;
    logic [CNT_W-1:0]    beat_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [LINE_W-1:0]   wdata_q;
    logic [LINE_W-1:0]   line_q;
    logic [BEAT_W-1:0]   mem_wdata_q;
    logic                mem_read_q;
    logic                mem_write_q;
    logic                i_resp_q;
    logic                d_resp_q;
    logic [LINE_W-1:0]   i_rdata_q;
    logic [LINE_W-1:0]   d_rdata_q;

    logic                d_req_c;
    logic                grant_d_c;
    logic                grant_i_c;
    logic                last_beat_c;
    logic [LINE_W-1:0]   line_fill_c;

    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign i_pmem_resp  = i_resp_q;
    assign d_pmem_resp  = d_resp_q;
    assign i_pmem_rdata = i_rdata_q;
    assign d_pmem_rdata = d_rdata_q;

    assign d_req_c     = d_pmem_read | d_pmem_write;
    assign last_beat_c = (beat_q == CNT_W'(BEATS - 1));

`ifdef PMEM_ARB_RR_EN
    // rr_q set means D is favoured on the next clash.
    logic rr_q;
    assign grant_d_c = d_req_c & (~i_pmem_read | rr_q);
`else
    assign grant_d_c = d_req_c;
`endif
    assign grant_i_c = i_pmem_read & ~grant_d_c;

    // Line as it will look once the current read beat is stored.
    always_comb begin
        line_fill_c = line_q;
        line_fill_c[int'(beat_q) * BEAT_W +: BEAT_W] = mem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            line_q      <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef PMEM_ARB_RR_EN
            rr_q        <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    if (grant_d_c) begin
                        addr_q <= d_pmem_addr & LINE_MASK;
                        if (d_pmem_write) begin
                            state_q     <= D_WR;
                            mem_write_q <= 1'b1;
                            wdata_q     <= d_pmem_wdata;
                            mem_wdata_q <= d_pmem_wdata[BEAT_W-1:0];
                        end else begin
                            state_q    <= D_RD;
                            mem_read_q <= 1'b1;
                        end
`ifdef PMEM_ARB_RR_EN
                        rr_q <= 1'b0;
`endif
                    end else if (grant_i_c) begin
                        addr_q     <= i_pmem_addr & LINE_MASK;
                        state_q    <= I_RD;
                        mem_read_q <= 1'b1;
`ifdef PMEM_ARB_RR_EN
                        rr_q <= 1'b1;
`endif
                    end
                end
                I_RD, D_RD: begin
                    if (mem_resp) begin
                        line_q <= line_fill_c;
                        beat_q <= beat_q + CNT_W'(1);
                        if (last_beat_c) begin
                            state_q    <= RESP;
                            mem_read_q <= 1'b0;
                            if (state_q == I_RD) begin
                                i_resp_q  <= 1'b1;
                                i_rdata_q <= line_fill_c;
                            end else begin
                                d_resp_q  <= 1'b1;
                                d_rdata_q <= line_fill_c;
                            end
                        end
                    end
                end
                D_WR: begin
                    if (mem_resp) begin
                        beat_q <= beat_q + CNT_W'(1);
                        if (last_beat_c) begin
                            state_q     <= RESP;
                            mem_write_q <= 1'b0;
                            mem_wdata_q <= '0;
                            d_resp_q    <= 1'b1;
                            d_rdata_q   <= '0;
                        end else begin
                            mem_wdata_q <= wdata_q[(int'(beat_q) + 1) * BEAT_W +: BEAT_W];
                        end
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    beat_q    <= '0;
                    i_resp_q  <= 1'b0;
                    d_resp_q  <= 1'b0;
                    i_rdata_q <= '0;
                    d_rdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
